// File: rtl/limit_counter.sv
// limit_counter: prescaled up/down counter with programmable limit and wrap/saturate/bounce/one-shot modes
module limit_counter #(
  parameter int Size = 8,
  parameter int PrescaleSize = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    direction,
  input  logic [1:0]              mode,
  input  logic [Size-1:0]         limit,
  input  logic [PrescaleSize-1:0] prescale,
  input  logic                    load,
  input  logic [Size-1:0]         load_data,
  output logic [Size-1:0]         data_o,
  output logic                    tick_o,
  output logic                    wrap_o,
  output logic                    done_o,
  output logic                    dir_o,
  output logic                    at_limit_o,
  output logic                    at_zero_o
);
  logic [PrescaleSize-1:0] pre_cnt;
  logic dir_q, step, live, up, term;
  logic [Size-1:0] clamp, term_val, next_val;
  assign step = enable && !load && pre_cnt == prescale;
  assign live = step && !(mode == 2'b11 && done_o);
  assign dir_o = mode == 2'b10 ? dir_q : direction;
  assign up = !dir_o;
  assign term = up ? data_o >= limit : data_o == '0;
  assign clamp = data_o > limit ? limit : data_o;
  // saturate and one-shot both settle on the clamped value; down-terminal is 0 so clamp holds it
  assign term_val = mode == 2'b00 ? (up ? '0 : limit) :
                    mode == 2'b10 ? (limit == '0 ? '0 : (up ? limit - 1'b1 : Size'(1))) : clamp;
  assign next_val = term ? term_val : (up ? data_o + 1'b1 : data_o - 1'b1);
  assign at_limit_o = data_o == limit;
  assign at_zero_o = data_o == '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      data_o  <= '0;
      pre_cnt <= '0;
      dir_q   <= 1'b0;
      done_o  <= 1'b0;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else if (load) begin
      data_o  <= load_data > limit ? limit : load_data;
      pre_cnt <= '0;
      dir_q   <= direction;
      done_o  <= 1'b0;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else begin
      if (enable) pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      tick_o <= live;
      wrap_o <= live && term && mode != 2'b01;
      if (live) begin
        data_o <= next_val;
        if (term && mode == 2'b10) dir_q <= up;
        if (term && mode == 2'b11) done_o <= 1'b1;
      end
    end
  end
endmodule
